// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix-vector engine.
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } mv_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Widen a prod_w-bit product to 64 bits, sign- or zero-extending.
  function automatic logic [63:0] ext_prod(input logic [63:0] prod,
                                           input int unsigned prod_w,
                                           input bit is_signed);
    logic [63:0] mask;
    logic        msb;
    mask = (prod_w >= 64) ? '1 : ((64'd1 << prod_w) - 64'd1);
    msb  = is_signed && (((prod >> (prod_w - 1)) & 64'd1) != 64'd0);
    return (prod & mask) | (msb ? ~mask : 64'd0);
  endfunction

endpackage

// File: rtl/matvec_engine_mac_lane.sv
// One multiply-accumulate lane: acc += ext(a*b) when en, cleared by clr.
module mac_lane
  import matvec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  logic [PROD_W-1:0]    a_x, b_x, prod;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  // Operands widened first so the low PROD_W bits hold the exact product.
  always_comb begin
    a_x   = (SIGNED != 0) ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : {{DATA_WIDTH{1'b0}}, a};
    b_x   = (SIGNED != 0) ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
    prod  = a_x * b_x;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_WIDTH'(ext_prod(64'(prod), PROD_W, SIGNED != 0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector engine: fetches B and A over Avalon-MM, computes C = A*B
// with one MAC lane per row, then streams C out.
module matvec_engine
  import matvec_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned ROWS       = 8,
  parameter  int unsigned COLS       = 8,
  parameter  int unsigned ACC_WIDTH  = 24,
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned SIGNED     = 0,
  localparam int unsigned MEM_W      = COLS * DATA_WIDTH,
  localparam int unsigned IDX_W      = clog2(((ROWS > COLS) ? ROWS : COLS) + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      acc_mode,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH-1:0]     address,
  output logic                      read,
  input  logic [MEM_W-1:0]          readdata,
  input  logic                      readdatavalid,
  input  logic                      waitrequest,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_WIDTH-1:0]      res_data,
  output logic [IDX_W-1:0]          res_idx,
  output logic [ROWS*ACC_WIDTH-1:0] c_out
);

  mv_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic                  read_q, read_d, pend_q, pend_d;
  logic                  busy_q, busy_d, valid_q, valid_d;
  logic [IDX_W-1:0]      word_q, word_d, col_q, col_d, idx_q, idx_d;
  logic [ACC_WIDTH-1:0]  data_q, data_d;
  logic [MEM_W-1:0]      b_q, b_d;
  logic [MEM_W-1:0]      a_q [ROWS];
  logic [MEM_W-1:0]      a_d [ROWS];

  logic                  clr_c, en_c, accept_c, last_c;
  logic [DATA_WIDTH-1:0] b_col;
  logic [DATA_WIDTH-1:0] a_col [ROWS];
  logic [ACC_WIDTH-1:0]  acc_w [ROWS];
  logic [2*DATA_WIDTH-1:0] a0_x, b0_x, prod0;
  logic [ACC_WIDTH-1:0]  acc0_nxt, drain_nxt;

  // Column select for the current COMPUTE step.
  always_comb begin
    b_col = '0;
    for (int unsigned r = 0; r < ROWS; r++) a_col[r] = '0;
    for (int unsigned k = 0; k < COLS; k++) begin
      if (col_q == IDX_W'(k)) begin
        b_col = b_q[k*DATA_WIDTH +: DATA_WIDTH];
        for (int unsigned r = 0; r < ROWS; r++) a_col[r] = a_q[r][k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Row 0's post-update value, so the first drain beat can be registered
  // on the same edge that completes the last MAC step.
  always_comb begin
    a0_x     = (SIGNED != 0) ? {{DATA_WIDTH{a_col[0][DATA_WIDTH-1]}}, a_col[0]}
                             : {{DATA_WIDTH{1'b0}}, a_col[0]};
    b0_x     = (SIGNED != 0) ? {{DATA_WIDTH{b_col[DATA_WIDTH-1]}}, b_col}
                             : {{DATA_WIDTH{1'b0}}, b_col};
    prod0    = a0_x * b0_x;
    acc0_nxt = acc_w[0] + ACC_WIDTH'(ext_prod(64'(prod0), 2 * DATA_WIDTH, SIGNED != 0));
    drain_nxt = '0;
    for (int unsigned r = 0; r + 1 < ROWS; r++) begin
      if (idx_q == IDX_W'(r)) drain_nxt = acc_w[r+1];
    end
  end

  assign accept_c = valid_q & res_ready;
  assign last_c   = (idx_q == IDX_W'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    read_d  = read_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    word_d  = word_q;
    col_d   = col_q;
    idx_d   = idx_q;
    data_d  = data_q;
    b_d     = b_q;
    for (int unsigned r = 0; r < ROWS; r++) a_d[r] = a_q[r];
    clr_c   = 1'b0;
    en_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          base_d  = base_addr;
          addr_d  = base_addr;
          read_d  = 1'b1;
          busy_d  = 1'b1;
          word_d  = '0;
          clr_c   = ~acc_mode;
        end
      end
      FETCH: begin
        if (read_q && !waitrequest) begin
          read_d = 1'b0;
          pend_d = 1'b1;
        end
        if (pend_q && readdatavalid) begin
          pend_d = 1'b0;
          word_d = word_q + IDX_W'(1);
          if (word_q == '0) b_d = readdata;
          for (int unsigned r = 0; r < ROWS; r++) begin
            if (word_q == IDX_W'(r + 1)) a_d[r] = readdata;
          end
          if (word_q == IDX_W'(ROWS)) begin
            state_d = COMPUTE;
            col_d   = '0;
          end else begin
            read_d = 1'b1;
            addr_d = base_q + ADDR_WIDTH'(word_q) + ADDR_WIDTH'(1);
          end
        end
      end
      COMPUTE: begin
        en_c  = 1'b1;
        col_d = col_q + IDX_W'(1);
        if (col_q == IDX_W'(COLS - 1)) begin
          state_d = DRAIN;
          col_d   = '0;
          valid_d = 1'b1;
          idx_d   = '0;
          data_d  = acc0_nxt;
        end
      end
      DRAIN: begin
        if (accept_c) begin
          if (last_c) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            idx_d   = '0;
            data_d  = '0;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = drain_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      word_q  <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      b_q     <= '0;
      for (int unsigned r = 0; r < ROWS; r++) a_q[r] <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      b_q     <= b_d;
      for (int unsigned r = 0; r < ROWS; r++) a_q[r] <= a_d[r];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SIGNED    (SIGNED)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .clr(clr_c),
      .en (en_c),
      .a  (a_col[r]),
      .b  (b_col),
      .acc(acc_w[r])
    );
    assign c_out[r*ACC_WIDTH +: ACC_WIDTH] = acc_w[r];
  end

  // The final beat's handshake and its done pulse share a cycle.
  assign done      = accept_c & last_c;
  assign busy      = busy_q;
  assign address   = addr_q;
  assign read      = read_q;
  assign res_valid = valid_q;
  assign res_data  = data_q;
  assign res_idx   = idx_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Bench for matvec_engine: unsigned and signed instances share one memory
// model; results are compared with an arithmetic reference of C = A*B.
module tb_matvec_engine;

  localparam int unsigned DW = 8, ROWS = 8, COLS = 8, AW = 24, ADW = 32;
  localparam int unsigned MEM_W = COLS * DW, IDX_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, acc_mode, res_ready;
  logic [ADW-1:0]   base_addr;
  logic [MEM_W-1:0] readdata;
  logic             readdatavalid, waitrequest;

  logic             busy_u, done_u, read_u, res_valid_u;
  logic [ADW-1:0]   address_u;
  logic [AW-1:0]    res_data_u;
  logic [IDX_W-1:0] res_idx_u;
  logic [ROWS*AW-1:0] c_out_u;
  logic             busy_s, done_s, read_s, res_valid_s;
  logic [ADW-1:0]   address_s;
  logic [AW-1:0]    res_data_s;
  logic [IDX_W-1:0] res_idx_s;
  logic [ROWS*AW-1:0] c_out_s;

  matvec_engine #(.SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .base_addr(base_addr),
    .busy(busy_u), .done(done_u), .address(address_u), .read(read_u),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .res_valid(res_valid_u), .res_ready(res_ready), .res_data(res_data_u),
    .res_idx(res_idx_u), .c_out(c_out_u));

  matvec_engine #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode), .base_addr(base_addr),
    .busy(busy_s), .done(done_s), .address(address_s), .read(read_s),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s),
    .res_idx(res_idx_s), .c_out(c_out_s));

  int checks = 0;
  int errors = 0;
  logic [MEM_W-1:0] mem [64];
  int mem_waits = 0;
  int mem_lat   = 1;
  int acc_reads = 0;
  bit stray     = 1'b0;
  longint prev_u [ROWS];
  longint prev_s [ROWS];
  longint exp_u  [ROWS];
  longint exp_s  [ROWS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Avalon slave: fixed stall per request, fixed data latency.
  initial begin
    logic snap_acc, snap_rd, snap_rst;
    logic [ADW-1:0] snap_addr;
    int age, q_rem;
    bit q_busy;
    logic [MEM_W-1:0] q_data;
    readdatavalid = 1'b0; waitrequest = 1'b0; readdata = '0;
    age = 0; q_rem = 0; q_busy = 1'b0; q_data = '0;
    forever begin
      @(negedge clk);
      snap_acc  = read_u && !waitrequest;
      snap_rd   = read_u;
      snap_addr = address_u;
      snap_rst  = rst;
      @(posedge clk); #1;
      if (snap_rst) begin q_busy = 1'b0; age = 0; end
      if (snap_acc && !snap_rst) begin
        acc_reads++;
        q_busy = 1'b1; q_rem = mem_lat; q_data = mem[snap_addr[5:0]];
      end
      readdatavalid = 1'b0;
      readdata = {$urandom, $urandom};
      if (q_busy) begin
        q_rem--;
        if (q_rem == 0) begin readdatavalid = 1'b1; readdata = q_data; q_busy = 1'b0; end
      end
      if (stray) begin readdatavalid = 1'b1; readdata = {$urandom, $urandom}; stray = 1'b0; end
      if (snap_rd && !snap_acc && !snap_rst) begin
        check("read_hold", 64'(read_u), 64'd1);
        check("addr_hold", 64'(address_u), 64'(snap_addr));
      end
      age = (read_u && snap_rd && !snap_acc) ? age + 1 : 0;
      waitrequest = read_u && (age < mem_waits);
    end
  end

  function automatic longint elem(input logic [MEM_W-1:0] w, input int k, input bit sg);
    logic [DW-1:0] e;
    e = w[k*DW +: DW];
    return sg ? longint'($signed(e)) : longint'(e);
  endfunction

  // C = (mode ? C_prev : 0) + A*B, wrapped to the accumulator width.
  task automatic model(input int base, input bit mode);
    for (int r = 0; r < ROWS; r++) begin
      longint su, ss;
      su = mode ? prev_u[r] : 0;
      ss = mode ? prev_s[r] : 0;
      for (int k = 0; k < COLS; k++) begin
        su += elem(mem[base+1+r], k, 1'b0) * elem(mem[base], k, 1'b0);
        ss += elem(mem[base+1+r], k, 1'b1) * elem(mem[base], k, 1'b1);
      end
      exp_u[r] = su & 64'hFFFFFF;
      exp_s[r] = ss & 64'hFFFFFF;
    end
  endtask

  task automatic do_run(input int base, input bit mode, input int rmode, output int busy_cyc);
    int idx, p;
    bit seen_done, stalled, first;
    logic [AW-1:0] last_data;
    logic [IDX_W-1:0] last_idx;
    model(base, mode);
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADW'(base); acc_mode = mode;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; acc_mode = ~mode;
    busy_cyc = 0; idx = 0; p = 0; stalled = 0; seen_done = 0; first = 1; last_data = '0; last_idx = '0;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      @(negedge clk);
      if (busy_u) busy_cyc++;
      if (res_valid_u) begin
        if (first) begin
          for (int r = 0; r < ROWS; r++) begin
            check($sformatf("c_out_u[%0d]", r), 64'(c_out_u[r*AW +: AW]), 64'(exp_u[r]));
            check($sformatf("c_out_s[%0d]", r), 64'(c_out_s[r*AW +: AW]), 64'(exp_s[r]));
          end
          first = 0;
        end
        if (stalled) begin
          check("stall_data", 64'(res_data_u), 64'(last_data));
          check("stall_idx", 64'(res_idx_u), 64'(last_idx));
        end
        check("res_idx", 64'(res_idx_u), 64'(idx));
        if (idx < ROWS) begin
          check($sformatf("res_data_u[%0d]", idx), 64'(res_data_u), 64'(exp_u[idx]));
          check($sformatf("res_data_s[%0d]", idx), 64'(res_data_s), 64'(exp_s[idx]));
        end
        last_data = res_data_u; last_idx = res_idx_u; stalled = !res_ready;
        if (res_ready) idx++;
      end
      if (done_u) begin
        seen_done = 1;
        check("done_u_at_last_beat", {61'(res_idx_u), res_valid_u, res_ready}, {61'(ROWS - 1), 1'b1, 1'b1});
        check("done_s", 64'(done_s), 64'd1);
      end
      @(posedge clk); #1;
      p++;
      case (rmode)
        0:       res_ready = 1'b1;
        1:       res_ready = ((p % 3) == 0);
        default: res_ready = 1'($urandom_range(0, 1));
      endcase
    end
    check("done_seen", 64'(seen_done), 64'd1);
    check("beats", 64'(idx), 64'(ROWS));
    @(negedge clk);
    check("busy_falls", 64'(busy_u), 64'd0);
    check("read_idle", 64'(read_u), 64'd0);
    res_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin prev_u[r] = exp_u[r]; prev_s[r] = exp_s[r]; end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_read"}, 64'(read_u), 64'd0);
    check({tag, "_address"}, 64'(address_u), 64'd0);
    check({tag, "_busy"}, 64'(busy_u), 64'd0);
    check({tag, "_done"}, 64'(done_u), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid_u), 64'd0);
    check({tag, "_res_data"}, 64'(res_data_u), 64'd0);
    check({tag, "_res_idx"}, 64'(res_idx_u), 64'd0);
    check({tag, "_c_out_u_zero"}, 64'(c_out_u == '0), 64'd1);
    check({tag, "_c_out_s_zero"}, 64'(c_out_s == '0), 64'd1);
  endtask

  initial begin
    int bc;
    rst = 1'b1; start = 1'b0; acc_mode = 1'b0; base_addr = '0; res_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
    for (int k = 0; k < COLS; k++) mem[0][k*DW +: DW] = DW'(k + 1);
    for (int r = 0; r < ROWS; r++) begin
      mem[1+r] = '0;
      mem[1+r][r*DW +: DW] = 8'd1;
    end
    for (int i = 16; i < 25; i++) mem[i] = '1;
    for (int r = 0; r < ROWS; r++) begin prev_u[r] = 0; prev_s[r] = 0; end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Identity, zero-wait memory: C = [1..8], 34 busy cycles, 9 reads.
    acc_reads = 0;
    do_run(0, 1'b0, 0, bc);
    check("identity_busy_cycles", 64'(bc), 64'd34);
    check("identity_reads", 64'(acc_reads), 64'd9);
    check("identity_c7", 64'(c_out_u[7*AW +: AW]), 64'd8);

    // All 0xFF: 520200 unsigned, 8 signed.
    do_run(16, 1'b0, 0, bc);
    check("ff_unsigned", 64'(c_out_u[0 +: AW]), 64'd520200);
    check("ff_signed", 64'(c_out_s[5*AW +: AW]), 64'd8);

    // Stalling slave with 2-cycle data latency.
    mem_waits = 3; mem_lat = 2; acc_reads = 0;
    do_run(0, 1'b0, 0, bc);
    check("stall_reads", 64'(acc_reads), 64'd9);
    mem_waits = 0; mem_lat = 1;

    // Back-pressure 1,0,0 on the result stream.
    do_run(0, 1'b0, 1, bc);

    // Tiling: accumulate onto previous C, then clear again.
    do_run(0, 1'b1, 0, bc);
    check("tile_c7", 64'(c_out_u[7*AW +: AW]), 64'd16);
    do_run(0, 1'b0, 0, bc);
    check("retile_c3", 64'(c_out_u[3*AW +: AW]), 64'd4);

    // Random matrix with random back-pressure, plus an accumulate pass.
    do_run(32, 1'b0, 2, bc);
    do_run(32, 1'b1, 2, bc);

    // Reset mid-COMPUTE, stray readdatavalid afterwards.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'd0; acc_mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    check("midrun_busy", 64'(busy_u), 64'd1);
    check("midrun_no_read", 64'(read_u), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("midrst");
    for (int r = 0; r < ROWS; r++) begin prev_u[r] = 0; prev_s[r] = 0; end
    do_run(0, 1'b1, 0, bc);
    check("post_reset_busy_cycles", 64'(bc), 64'd34);
    check("post_reset_c0", 64'(c_out_u[0 +: AW]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
